// File: rtl/isa_pkg.sv
// ISA constants shared by the instruction encoder/loader: formats, opcode maps,
// legality rules and loader session states.
package isa_pkg;

  typedef enum logic {
    FMT_REG = 1'b0,
    FMT_IMM = 1'b1
  } fmt_e;

  localparam logic [8:0] OP_NOP      = 9'd0;
  localparam logic [8:0] OP_ADD      = 9'd1;
  localparam logic [8:0] OP_AND      = 9'd2;
  localparam logic [8:0] OP_SUB      = 9'd3;
  localparam logic [8:0] OP_OR       = 9'd4;
  localparam logic [8:0] OP_XOR      = 9'd5;
  localparam logic [8:0] OP_MOVE     = 9'd6;
  localparam logic [8:0] OP_NOT      = 9'd8;
  localparam logic [8:0] OP_SAR      = 9'd9;
  localparam logic [8:0] OP_SLR      = 9'd10;
  localparam logic [8:0] OP_SAL      = 9'd11;
  localparam logic [8:0] OP_SLL      = 9'd12;
  localparam logic [8:0] OP_ROL      = 9'd13;
  localparam logic [8:0] OP_ROR      = 9'd14;
  localparam logic [8:0] OP_INC      = 9'd15;
  localparam logic [8:0] OP_DEC      = 9'd16;
  localparam logic [8:0] OP_SHOWR    = 9'd18;
  localparam logic [8:0] OP_SHOWRSEG = 9'd19;
  localparam logic [8:0] OP_CMP      = 9'd20;

  localparam logic [3:0] OP4_JMP_LO = 4'd0;
  localparam logic [3:0] OP4_JMP_HI = 4'd5;
  localparam logic [3:0] OP4_LI     = 4'd6;
  localparam logic [3:0] OP4_LM     = 4'd7;
  localparam logic [3:0] OP4_ST     = 4'd8;
  localparam logic [3:0] OP4_LDIP   = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } ld_state_e;

  // Codes 7 and 17 are holes in the ALU map; everything above CMP is unassigned.
  function automatic logic alu_op_legal(input logic [8:0] op);
    return (op <= OP_MOVE) ||
           ((op >= OP_NOT) && (op <= OP_DEC)) ||
           ((op >= OP_SHOWR) && (op <= OP_CMP));
  endfunction

  function automatic logic op4_legal(input logic [3:0] op4);
    return op4 <= OP4_LDIP;
  endfunction

  function automatic logic [15:0] encode(input fmt_e fmt, input logic [8:0] op,
                                         input logic [2:0] ra, input logic [2:0] rb,
                                         input logic [7:0] imm);
    if (fmt == FMT_IMM) return {1'b1, op[3:0], ra, imm};
    else                return {1'b0, op, ra, rb};
  endfunction

endpackage

// File: rtl/inst_enc_loader_if.sv
// Host-side field handshake and instruction-memory write port of the loader.
interface inst_enc_loader_if #(
  parameter int AW = 8
);
  logic          i_start;
  logic [AW-1:0] i_base;
  logic          i_valid;
  logic          o_ready;
  logic          i_fmt;
  logic [8:0]    i_op;
  logic [2:0]    i_ra;
  logic [2:0]    i_rb;
  logic [7:0]    i_imm;
  logic          i_last;
  logic          i_mem_ready;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic [15:0]   o_wr_data;
  logic          o_done;
  logic [AW:0]   o_count;
  logic          o_err;
  logic          o_wrap;

  modport slave (
    input  i_start, i_base, i_valid, i_fmt, i_op, i_ra, i_rb, i_imm, i_last, i_mem_ready,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done, o_count, o_err, o_wrap
  );

  modport master (
    output i_start, i_base, i_valid, i_fmt, i_op, i_ra, i_rb, i_imm, i_last, i_mem_ready,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_done, o_count, o_err, o_wrap
  );
endinterface

// File: rtl/inst_fifo.sv
// Synchronous first-word-fall-through FIFO for encoded instruction words.
module inst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW:0]      cnt;
  logic             wr;
  logic             rd;

  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/inst_enc_loader.sv
// Encodes instruction fields into 16-bit ISA words, drops illegal ones and
// streams the rest into instruction memory from a programmable base address.
module inst_enc_loader
  import isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  inst_enc_loader_if.slave  bus
);
  localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

  ld_state_e   state;
  ld_state_e   state_d;
  logic        ready;
  logic        done;
  logic        accept;
  logic        legal;
  logic [15:0] word;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [15:0] fifo_dout;

  logic [AW-1:0] addr;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          wr_en;
  logic [AW:0]   count;
  logic          err;
  logic          wrap;

  always_comb begin
    legal = (bus.i_fmt == FMT_IMM) ? op4_legal(bus.i_op[3:0]) : alu_op_legal(bus.i_op);
    word  = encode(fmt_e'(bus.i_fmt), bus.i_op, bus.i_ra, bus.i_rb, bus.i_imm);
  end

  assign accept = bus.i_valid && ready;
  assign push   = accept && legal;
  assign pop    = !empty && bus.i_mem_ready && (state != ST_IDLE);

  inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .din   (word),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_d;
  end

  // Ready looks only at the registered fill level, so a same-cycle pop never
  // reopens a full FIFO.
  always_comb begin
    state_d = state;
    ready   = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.i_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ready = !full;
        if (accept && bus.i_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (empty && !wr_en) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      count   <= '0;
      err     <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wr_en <= pop;
      if (state == ST_IDLE && bus.i_start) begin
        addr  <= bus.i_base;
        count <= '0;
        err   <= 1'b0;
        wrap  <= 1'b0;
      end
      if (pop) begin
        wr_data <= fifo_dout;
        wr_addr <= addr;
        addr    <= addr + 1'b1;
        if (addr == '1) wrap <= 1'b1;
        if (count != COUNT_MAX) count <= count + 1'b1;
      end
      if (accept && !legal) err <= 1'b1;
    end
  end

  assign bus.o_ready   = ready;
  assign bus.o_done    = done;
  assign bus.o_wr_en   = wr_en;
  assign bus.o_wr_addr = wr_addr;
  assign bus.o_wr_data = wr_data;
  assign bus.o_count   = count;
  assign bus.o_err     = err;
  assign bus.o_wrap    = wrap;

endmodule
